// File: rtl/timer_share_ctrl_pkg.sv
// timer_share_ctrl_pkg: shared state encodings and default widths for the timer share controller.
package timer_share_ctrl_pkg;

   localparam int NREQ_DEF = 4;
   localparam int CW_DEF   = 20;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/timer_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last+1 with wrap.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] pick,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   logic [IW-1:0] j;

   always_comb begin
      pick  = '0;
      idx   = '0;
      valid = 1'b0;
      j     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IW'((int'(last) + k) % NREQ);
         if (!valid && req[j]) begin
            valid   = 1'b1;
            idx     = j;
            pick[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_share_ctrl.sv
// timer_share_ctrl: round-robin sharing of one up-counter among NREQ interval requesters.
// Define TSC_ABORT_EN to let an owner abandon its interval by dropping req.
module timer_share_ctrl
   import timer_share_ctrl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*CW-1:0] len,
   output logic [NREQ-1:0]  grant,
   output logic [NREQ-1:0]  done,
   output logic             busy,
   output logic             cnt_clr,
   output logic             cnt_en,
   input  logic [CW-1:0]    cnt_val,
   input  logic             cnt_max
);

   localparam int IW = $clog2(NREQ);

   state_t          state, next;
   logic [IW-1:0]   last, owner, pick_idx;
   logic [NREQ-1:0] pick;
   logic            pick_vld, match, abort;
   logic [CW-1:0]   len_q;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .last  (last),
      .pick  (pick),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // cnt_max without a length match can only be a counter fault; finish rather than wrap
   assign match = (cnt_val == len_q) || cnt_max;

`ifdef TSC_ABORT_EN
   assign abort = (state == S_CLEAR || state == S_RUN) && !req[owner];
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      next    = state;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         S_IDLE:  next = pick_vld ? S_CLEAR : S_IDLE;
         S_CLEAR: begin
            next    = abort ? S_IDLE : S_RUN;
            cnt_clr = !abort;
         end
         S_RUN: begin
            next   = abort ? S_IDLE : (match ? S_DONE : S_RUN);
            cnt_en = !abort && !match;
         end
         S_DONE:  next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
         len_q <= '0;
         owner <= '0;
         last  <= IW'(NREQ - 1);
      end else begin
         state <= next;
         busy  <= next != S_IDLE;
         done  <= next == S_DONE ? grant : '0;
         if (state == S_IDLE && pick_vld) begin
            grant <= pick;
            owner <= pick_idx;
            len_q <= len[int'(pick_idx)*CW +: CW];
         end
         if (state != S_IDLE && next == S_IDLE) begin
            grant <= '0;
            last  <= owner;
         end
      end
   end

endmodule

// File: tb/tb_timer_share_ctrl.sv
// tb_timer_share_ctrl: scoreboard bench for timer_share_ctrl with a behavioural shared counter.
module tb_timer_share_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0]  req = '0, grant, done;
   logic [79:0] len = '0;
   logic        busy, cnt_clr, cnt_en, cnt_max;
   logic        force_max = 1'b0;
   logic [19:0] cnt = '0;

   always @(posedge clk) cnt <= cnt_clr ? 20'd0 : (cnt_en ? cnt + 20'd1 : cnt);
   assign cnt_max = (&cnt) | force_max;

   timer_share_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .len(len), .grant(grant), .done(done),
      .busy(busy), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_val(cnt), .cnt_max(cnt_max)
   );

   logic [1:0] req2 = '0, grant2, done2;
   logic [7:0] len2 = '0;
   logic       busy2, clr2, en2, max2;
   logic [3:0] cnt2 = '0;

   always @(posedge clk) cnt2 <= clr2 ? 4'd0 : (en2 ? cnt2 + 4'd1 : cnt2);
   assign max2 = &cnt2;

   timer_share_ctrl #(.NREQ(2), .CW(4)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .len(len2), .grant(grant2), .done(done2),
      .busy(busy2), .cnt_clr(clr2), .cnt_en(en2), .cnt_val(cnt2), .cnt_max(max2)
   );

   typedef struct {
      int         cyc;
      logic [3:0] vec;
      int         ens;
      int         cnt;
   } exp_t;

   exp_t q[$];
   exp_t q2[$];
   int   ens = 0;
   int   ens2 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // enable cycles are counted per interval so each done can be checked against its length
   always @(negedge clk) begin
      ens <= cnt_clr ? 0 : ens + (cnt_en ? 1 : 0);
      if (done != 0) begin
         if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
         else begin
            chk("done_cycle", cyc, q[0].cyc);
            chk("done_vec", 32'(done), 32'(q[0].vec));
            chk("grant_at_done", 32'(grant), 32'(q[0].vec));
            chk("en_cycles", ens, q[0].ens);
            chk("cnt_at_done", 32'(cnt), q[0].cnt);
            void'(q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      ens2 <= clr2 ? 0 : ens2 + (en2 ? 1 : 0);
      if (done2 != 0) begin
         if (q2.size() == 0) chk("unexpected_done2", 32'(done2), 0);
         else begin
            chk("done2_cycle", cyc, q2[0].cyc);
            chk("done2_vec", 32'(done2), 32'(q2[0].vec));
            chk("en2_cycles", ens2, q2[0].ens);
            chk("cnt2_at_done", 32'(cnt2), q2[0].cnt);
            chk("max2_at_done", 32'(max2), 1);
            void'(q2.pop_front());
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (done == 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (done == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int c, n, t;
      do_reset();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_clr", 32'(cnt_clr), 0);
      chk("rst_en", 32'(cnt_en), 0);

      // single request, len 5
      len[19:0] = 20'd5;
      req = 4'b0001;
      c = cyc;
      q.push_back('{c + 8, 4'b0001, 5, 5});
      @(negedge clk);
      chk("grant_first", 32'(grant), 32'h1);
      chk("clr_pulse", 32'(cnt_clr), 1);
      chk("busy_clear", 32'(busy), 1);
      @(negedge clk);
      chk("clr_one_cycle", 32'(cnt_clr), 0);
      chk("en_run", 32'(cnt_en), 1);
      wait_done(40);
      req = 4'b0000;
      @(negedge clk);
      chk("busy_after", 32'(busy), 0);
      chk("grant_after", 32'(grant), 0);

      // all four held, len 2 each: round-robin order from reset
      do_reset();
      len = {4{20'd2}};
      req = 4'b1111;
      c = cyc;
      for (int k = 0; k < 5; k++) q.push_back('{c + 5 + 6*k, 4'(1 << (k % 4)), 2, 2});
      n = 0;
      t = 0;
      while (n < 5 && t < 100) begin
         @(negedge clk);
         t++;
         if (done != 0) n++;
      end
      req = 4'b0000;
      chk("rr_done_count", n, 5);
      @(negedge clk);

      // zero length finishes with no enable cycle
      len[19:0] = 20'd0;
      req = 4'b0001;
      c = cyc;
      q.push_back('{c + 3, 4'b0001, 0, 0});
      wait_done(20);
      req = 4'b0000;
      @(negedge clk);

      // reset mid-RUN abandons the interval
      len[19:0] = 20'd10;
      req = 4'b0001;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_en", 32'(cnt_en), 0);
      reset = 1'b0;
      req = 4'b0100;
      len[59:40] = 20'd1;
      c = cyc;
      q.push_back('{c + 4, 4'b0100, 1, 1});
      wait_done(20);
      req = 4'b0000;
      @(negedge clk);

      // owner drops req in the third RUN cycle
      len[19:0] = 20'd8;
      req = 4'b0001;
      c = cyc;
      repeat (4) @(negedge clk);
      req = 4'b0000;
      @(negedge clk);
`ifdef TSC_ABORT_EN
      chk("abort_grant", 32'(grant), 0);
      chk("abort_busy", 32'(busy), 0);
      repeat (15) @(negedge clk);
`else
      chk("noabort_grant", 32'(grant), 32'h1);
      q.push_back('{c + 11, 4'b0001, 8, 8});
      wait_done(20);
      @(negedge clk);
`endif

      // spurious cnt_max mid-interval ends it early
      len[39:20] = 20'd20;
      req = 4'b0010;
      c = cyc;
      repeat (5) @(negedge clk);
      force_max = 1'b1;
      q.push_back('{c + 6, 4'b0010, 3, 3});
      @(negedge clk);
      force_max = 1'b0;
      wait_done(20);
      req = 4'b0000;
      @(negedge clk);

      // all-ones length on a 4-bit counter: no wrap
      len2[3:0] = 4'hF;
      req2 = 2'b01;
      c = cyc;
      q2.push_back('{c + 18, 4'b0001, 15, 15});
      t = 0;
      while (done2 == 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (done2 == 0) chk("done2_timeout", 0, 1);
      req2 = 2'b00;
      repeat (3) @(negedge clk);
      chk("cnt2_no_wrap", 32'(cnt2), 32'hF);
      chk("busy2_after", 32'(busy2), 0);

      chk("queues_drained", q.size() + q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
